// File: rtl/idct_block_loader.sv
// Collects a 64-coefficient stream into an 8x8 block and presents it in raster order to the IDCT.
// Define IDCT_ZIGZAG_EN when the stream arrives in JPEG zigzag order; otherwise it is taken as raster order.
`timescale 1ns/1ps
module idct_block_loader #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    in_last,
   output logic signed [WIDTH-1:0] blk0,  blk1,  blk2,  blk3,  blk4,  blk5,  blk6,  blk7,
                                   blk8,  blk9,  blk10, blk11, blk12, blk13, blk14, blk15,
                                   blk16, blk17, blk18, blk19, blk20, blk21, blk22, blk23,
                                   blk24, blk25, blk26, blk27, blk28, blk29, blk30, blk31,
                                   blk32, blk33, blk34, blk35, blk36, blk37, blk38, blk39,
                                   blk40, blk41, blk42, blk43, blk44, blk45, blk46, blk47,
                                   blk48, blk49, blk50, blk51, blk52, blk53, blk54, blk55,
                                   blk56, blk57, blk58, blk59, blk60, blk61, blk62, blk63,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err
);

   typedef enum logic {FILL, HOLD} state_t;

`ifdef IDCT_ZIGZAG_EN
   localparam logic [5:0] ZIGZAG [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

   function automatic logic [5:0] map_idx(input logic [5:0] i);
      return ZIGZAG[i];
   endfunction
`else
   function automatic logic [5:0] map_idx(input logic [5:0] i);
      return i;
   endfunction
`endif

   state_t              state_reg, state_next;
   logic [5:0]          idx_reg, idx_next;
   logic                out_valid_reg, out_valid_next;
   logic                err_reg, err_next;
   logic                wr_en, xfer, xfer_beat, consume;
   logic [5:0]          wr_addr;
   logic signed [WIDTH-1:0] fill_reg [64];
   logic signed [WIDTH-1:0] blk_reg  [64];

   assign wr_addr = map_idx(idx_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= FILL;
         idx_reg       <= '0;
         out_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         out_valid_reg <= out_valid_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      out_valid_next = out_valid_reg;
      err_next       = err_reg;
      wr_en          = 1'b0;
      xfer           = 1'b0;
      xfer_beat      = 1'b0;
      in_ready       = (state_reg == FILL);
      consume        = out_valid_reg && out_ready;
      case (state_reg)
         FILL: begin
            if (in_valid) begin
               if (idx_reg == 6'd63) begin
                  // Beat 63 always closes the block; a missing in_last only flags err.
                  wr_en    = 1'b1;
                  idx_next = '0;
                  if (!in_last) err_next = 1'b1;
                  if (!out_valid_reg || consume) begin
                     xfer      = 1'b1;
                     xfer_beat = 1'b1;
                  end else begin
                     state_next = HOLD;
                  end
               end else if (in_last) begin
                  err_next = 1'b1;
                  idx_next = '0;
               end else begin
                  wr_en    = 1'b1;
                  idx_next = idx_reg + 6'd1;
               end
            end
         end
         HOLD: begin
            if (consume) begin
               xfer       = 1'b1;
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
      if (xfer)         out_valid_next = 1'b1;
      else if (consume) out_valid_next = 1'b0;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               fill_reg[gi] <= '0;
               blk_reg[gi]  <= '0;
            end else begin
               if (wr_en && wr_addr == 6'(gi)) fill_reg[gi] <= in_data;
               // Entry 63 maps to itself in both orders, so the closing beat bypasses the fill buffer.
               if (xfer) blk_reg[gi] <= (xfer_beat && gi == 63) ? in_data : fill_reg[gi];
            end
         end
      end
   endgenerate

   assign out_valid = out_valid_reg;
   assign err       = err_reg;

   assign blk0  = blk_reg[0];  assign blk1  = blk_reg[1];  assign blk2  = blk_reg[2];  assign blk3  = blk_reg[3];
   assign blk4  = blk_reg[4];  assign blk5  = blk_reg[5];  assign blk6  = blk_reg[6];  assign blk7  = blk_reg[7];
   assign blk8  = blk_reg[8];  assign blk9  = blk_reg[9];  assign blk10 = blk_reg[10]; assign blk11 = blk_reg[11];
   assign blk12 = blk_reg[12]; assign blk13 = blk_reg[13]; assign blk14 = blk_reg[14]; assign blk15 = blk_reg[15];
   assign blk16 = blk_reg[16]; assign blk17 = blk_reg[17]; assign blk18 = blk_reg[18]; assign blk19 = blk_reg[19];
   assign blk20 = blk_reg[20]; assign blk21 = blk_reg[21]; assign blk22 = blk_reg[22]; assign blk23 = blk_reg[23];
   assign blk24 = blk_reg[24]; assign blk25 = blk_reg[25]; assign blk26 = blk_reg[26]; assign blk27 = blk_reg[27];
   assign blk28 = blk_reg[28]; assign blk29 = blk_reg[29]; assign blk30 = blk_reg[30]; assign blk31 = blk_reg[31];
   assign blk32 = blk_reg[32]; assign blk33 = blk_reg[33]; assign blk34 = blk_reg[34]; assign blk35 = blk_reg[35];
   assign blk36 = blk_reg[36]; assign blk37 = blk_reg[37]; assign blk38 = blk_reg[38]; assign blk39 = blk_reg[39];
   assign blk40 = blk_reg[40]; assign blk41 = blk_reg[41]; assign blk42 = blk_reg[42]; assign blk43 = blk_reg[43];
   assign blk44 = blk_reg[44]; assign blk45 = blk_reg[45]; assign blk46 = blk_reg[46]; assign blk47 = blk_reg[47];
   assign blk48 = blk_reg[48]; assign blk49 = blk_reg[49]; assign blk50 = blk_reg[50]; assign blk51 = blk_reg[51];
   assign blk52 = blk_reg[52]; assign blk53 = blk_reg[53]; assign blk54 = blk_reg[54]; assign blk55 = blk_reg[55];
   assign blk56 = blk_reg[56]; assign blk57 = blk_reg[57]; assign blk58 = blk_reg[58]; assign blk59 = blk_reg[59];
   assign blk60 = blk_reg[60]; assign blk61 = blk_reg[61]; assign blk62 = blk_reg[62]; assign blk63 = blk_reg[63];

endmodule

// File: tb/tb_idct_block_loader.sv
// Directed/random bench for idct_block_loader; expected blocks come from a diagonal-walk zigzag model.
`timescale 1ns/1ps
module tb_idct_block_loader;
   localparam int W = 16;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic signed [W-1:0] in_data = '0;
   wire in_ready, out_valid, err;
   wire signed [W-1:0] blk [64];

   idct_block_loader #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .blk0(blk[0]),   .blk1(blk[1]),   .blk2(blk[2]),   .blk3(blk[3]),   .blk4(blk[4]),   .blk5(blk[5]),   .blk6(blk[6]),   .blk7(blk[7]),
      .blk8(blk[8]),   .blk9(blk[9]),   .blk10(blk[10]), .blk11(blk[11]), .blk12(blk[12]), .blk13(blk[13]), .blk14(blk[14]), .blk15(blk[15]),
      .blk16(blk[16]), .blk17(blk[17]), .blk18(blk[18]), .blk19(blk[19]), .blk20(blk[20]), .blk21(blk[21]), .blk22(blk[22]), .blk23(blk[23]),
      .blk24(blk[24]), .blk25(blk[25]), .blk26(blk[26]), .blk27(blk[27]), .blk28(blk[28]), .blk29(blk[29]), .blk30(blk[30]), .blk31(blk[31]),
      .blk32(blk[32]), .blk33(blk[33]), .blk34(blk[34]), .blk35(blk[35]), .blk36(blk[36]), .blk37(blk[37]), .blk38(blk[38]), .blk39(blk[39]),
      .blk40(blk[40]), .blk41(blk[41]), .blk42(blk[42]), .blk43(blk[43]), .blk44(blk[44]), .blk45(blk[45]), .blk46(blk[46]), .blk47(blk[47]),
      .blk48(blk[48]), .blk49(blk[49]), .blk50(blk[50]), .blk51(blk[51]), .blk52(blk[52]), .blk53(blk[53]), .blk54(blk[54]), .blk55(blk[55]),
      .blk56(blk[56]), .blk57(blk[57]), .blk58(blk[58]), .blk59(blk[59]), .blk60(blk[60]), .blk61(blk[61]), .blk62(blk[62]), .blk63(blk[63]),
      .out_valid(out_valid), .out_ready(out_ready), .err(err));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int map_tab [64];
   logic signed [W-1:0] stim [64];
   logic signed [W-1:0] exp_blk [64];
   logic signed [W-1:0] hold_blk [64];

   // Observers: consumed blocks, out_valid cycles and in_ready drops in the back-to-back run.
   int cyc = 0, consumed = 0, drops = 0;
   bit b2b = 1'b0;
   int pulse_cyc [$];
   always @(posedge clk) begin
      cyc++;
      if (rst_n && out_valid && out_ready) consumed++;
      if (b2b && out_valid) pulse_cyc.push_back(cyc);
      if (b2b && !in_ready) drops++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic void build_map();
      int n = 0;
      for (int s = 0; s < 15; s++) begin
         int lo, hi;
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin map_tab[n] = 8*r + (s-r); n++; end
         else            for (int r = lo; r <= hi; r++) begin map_tab[n] = 8*r + (s-r); n++; end
      end
`ifndef IDCT_ZIGZAG_EN
      for (int i = 0; i < 64; i++) map_tab[i] = i;
`endif
   endfunction

   function automatic void build_exp();
      for (int k = 0; k < 64; k++) exp_blk[k] = '0;
      for (int i = 0; i < 64; i++) exp_blk[map_tab[i]] = stim[i];
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_blk(input string tag);
      int bad = -1;
      for (int k = 0; k < 64; k++) if (bad < 0 && blk[k] !== exp_blk[k]) bad = k;
      tests++;
      assert (bad < 0) else begin
         fails++;
         $error("FAIL %s: blk%0d got %0d expected %0d", tag, bad, blk[bad], exp_blk[bad]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic signed [W-1:0] d, input bit l);
      int g = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      while (!in_ready && g < 300) begin tick(); g++; end
      if (!in_ready) begin
         tests++; fails++;
         $error("FAIL beat_timeout: in_ready got 0 expected 1");
      end
      tick();
   endtask

   task automatic send_block(input int n, input int last_at);
      for (int i = 0; i < n; i++) beat(stim[i], i == last_at);
   endtask

   task automatic idle();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic rand_stim();
      for (int i = 0; i < 64; i++) stim[i] = W'($urandom);
   endtask

   initial begin
      int c0;
      build_map();

      // Reset state
      tick(); tick();
      for (int k = 0; k < 64; k++) exp_blk[k] = '0;
      check_blk("reset_blk");
      rst_n = 1'b1;
      tick();
      check("reset_out_valid", out_valid, 0);
      check("reset_err", err, 0);
      check("reset_in_ready", in_ready, 1);

      // Small signed stream, consumer ready
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) stim[i] = '0;
      stim[0] = 23; stim[1] = -1; stim[2] = -2;
      send_block(64, 63); idle();
      build_exp();
      check("basic_out_valid", out_valid, 1);
      check_blk("basic_blk");
      check("basic_blk0", blk[0], 23);
      check("basic_blk1", blk[1], -1);
`ifdef IDCT_ZIGZAG_EN
      check("basic_blk8", blk[8], -2);
      check("basic_blk2", blk[2], 0);
`else
      check("basic_blk2", blk[2], -2);
      check("basic_blk8", blk[8], 0);
`endif
      check("basic_err", err, 0);
      tick();
      check("basic_consumed", out_valid, 0);
      check_blk("basic_stable");

      // Backpressure: second block held until out_ready pulse
      out_ready = 1'b0;
      rand_stim();
      send_block(64, 63); idle();
      build_exp();
      for (int k = 0; k < 64; k++) hold_blk[k] = exp_blk[k];
      check("bp_b1_valid", out_valid, 1);
      check_blk("bp_b1_blk");
      for (int i = 0; i < 64; i++) stim[i] = W'(i);
      send_block(64, 63); idle();
      check("bp_in_ready_low", in_ready, 0);
      check("bp_valid_held", out_valid, 1);
      check_blk("bp_b1_kept");
      tick(); tick();
      check("bp_still_held", in_ready, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      build_exp();
      check("bp_b2_valid", out_valid, 1);
      check_blk("bp_b2_blk");
      check("bp_b2_blk63", blk[63], 63);
      check("bp_in_ready_back", in_ready, 1);
      out_ready = 1'b1; tick();
      check("bp_b2_consumed", out_valid, 0);

      // Early in_last at beat 10, then a block of all 5
      c0 = consumed;
      rand_stim();
      send_block(11, 10);
      for (int i = 0; i < 64; i++) stim[i] = 16'sd5;
      send_block(64, 63); idle();
      tick(); tick(); tick();
      build_exp();
      check("early_err", err, 1);
      check("early_one_block", consumed - c0, 1);
      check_blk("early_all5");

      // Reset with a held block and a partial block in flight
      out_ready = 1'b0;
      rand_stim();
      send_block(64, 63);
      rand_stim();
      send_block(30, -1); idle();
      rst_n = 1'b0; #2;
      for (int k = 0; k < 64; k++) exp_blk[k] = '0;
      check("rst_out_valid", out_valid, 0);
      check("rst_err", err, 0);
      check_blk("rst_blk_zero");
      #1 rst_n = 1'b1;
      tick(); tick();
      check("rst_no_valid", out_valid, 0);
      c0 = consumed;
      out_ready = 1'b1;
      rand_stim();
      send_block(64, 63); idle();
      build_exp();
      check("rst_new_valid", out_valid, 1);
      check_blk("rst_new_blk");
      tick();
      check("rst_one_block", consumed - c0, 1);
      check("rst_err_clean", err, 0);

      // Missing in_last at beat 63 still completes the block
      rand_stim();
      send_block(64, -1); idle();
      build_exp();
      check("nolast_valid", out_valid, 1);
      check("nolast_err", err, 1);
      check_blk("nolast_blk");
      tick();
      rand_stim();
      send_block(64, 63); idle();
      build_exp();
      check_blk("nolast_next_blk");
      tick();

      // Back-to-back blocks, continuous in_valid
      pulse_cyc.delete();
      drops = 0;
      b2b = 1'b1;
      for (int b = 0; b < 4; b++) begin
         rand_stim();
         send_block(64, 63);
         build_exp();
         check("b2b_valid", out_valid, 1);
         check_blk("b2b_blk");
      end
      idle();
      tick(); tick();
      b2b = 1'b0;
      check("b2b_pulses", pulse_cyc.size(), 4);
      for (int i = 1; i < pulse_cyc.size(); i++) check("b2b_spacing", pulse_cyc[i] - pulse_cyc[i-1], 64);
      check("b2b_in_ready_drops", drops, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/idct_block_loader.md
IDCT_BLOCK_LOADER -- requirements
Module: idct_block_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the signed coefficient width.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the loader accepts in_data this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits, signed: one coefficient per accepted beat, in stream order.
REQ-007 The block SHALL have port in_last, input, 1 bit: marks the 64th coefficient of a block.
REQ-008 The block SHALL have ports blk0..blk63, output, WIDTH bits each, signed: completed 8x8 block in raster order, blk[8*row+col], wired directly to IDCT x0..x63.
REQ-009 The block SHALL have port out_valid, output, 1 bit: blk0..blk63 hold an unconsumed block.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the block.
REQ-011 The block SHALL have port err, output, 1 bit: sticky framing-error flag.

Function
REQ-012 A beat SHALL be accepted when in_valid and in_ready are both high; idx (6-bit) SHALL count accepted beats within the block, starting at 0.
REQ-013 An accepted beat SHALL be written into fill buffer entry map(idx), where map is defined in REQ-026/REQ-027.
REQ-014 The FSM SHALL have two states, FILL (in_ready=1) and HOLD (in_ready=0: the fill buffer is complete and the output slot is occupied).
REQ-015 At idx=63 with in_last=1, the block SHALL be complete: if the output slot is empty or is consumed that cycle (out_valid&&out_ready), the block SHALL transfer to blk0..blk63 at the next edge with out_valid=1, idx->0, and state FILL; otherwise the state SHALL go to HOLD.
REQ-016 Latency SHALL be 1 cycle: out_valid rises on the edge after the last beat is accepted.
REQ-017 In HOLD, when out_valid&&out_ready, the fill buffer SHALL transfer to the output, out_valid SHALL stay 1, and the state SHALL go to FILL, with in_ready high the following cycle.
REQ-018 out_valid SHALL clear on out_valid&&out_ready when no transfer occurs the same cycle; blk0..blk63 SHALL stay stable whenever no transfer occurs, including after consumption.
REQ-019 With out_ready held at 1 and in_valid continuous, throughput SHALL be one block per 64 cycles with no bubbles.
REQ-020 Early in_last (idx<63) SHALL set err, discard the partial block (no out_valid), and restart at idx=0 on the next beat.
REQ-021 A missing in_last at idx=63 SHALL set err and still complete the block per REQ-015.
REQ-022 Data values SHALL pass through unmodified, with no saturation or sign change.

Reset
REQ-023 While rst_n=0: state FILL, idx 0, out_valid 0, err 0, in_ready 1 (after reset deassertion), and all blk outputs and fill entries 0.
REQ-024 Reset mid-block SHALL discard partial and held blocks, with no out_valid until a full new block arrives.
REQ-025 err SHALL clear only on reset.

Configuration
REQ-026 With IDCT_ZIGZAG_EN defined, map SHALL be the JPEG zigzag-to-raster table (0->0, 1->1, 2->8, 3->16, 4->9, 5->2, ... 63->63).
REQ-027 Without IDCT_ZIGZAG_EN, map SHALL be the identity (stream is already raster order); no table logic SHALL be instantiated.

Verification
REQ-028 The bench SHALL cover, with IDCT_ZIGZAG_EN: stream 23,-1,-2, then 61 zeros, in_last on beat 63, out_ready=1 -> next cycle out_valid=1, blk0=23, blk1=-1, blk8=-2, all others 0, err=0.
REQ-029 The bench SHALL cover, without IDCT_ZIGZAG_EN: the same stream -> blk0=23, blk1=-1, blk2=-2, all others 0.
REQ-030 The bench SHALL cover backpressure: out_ready=0 while a second block of beats 0..63 equal to 0..63 is streamed -> in_ready drops after beat 63, blk keeps block 1; out_ready pulse -> block 2 appears next cycle and in_ready returns to 1.
REQ-031 The bench SHALL cover early in_last at beat 10, then a clean block of all 5 -> err=1, exactly one out_valid, all blk=5.
REQ-032 The bench SHALL cover rst_n pulsed low at beat 30 -> outputs 0, out_valid 0; the following full block is emitted correctly.
REQ-033 The bench SHALL cover back-to-back blocks with continuous in_valid and out_ready=1 -> out_valid pulses exactly 64 cycles apart and in_ready never drops.
